// File: rtl/mux_pkg.sv
// Shared encodings for the N-channel scanning multiplexer.
// Mode values match the external 2-bit mode pin.
package mux_pkg;

   typedef enum logic [1:0] {
      MODE_FIXED  = 2'b00,
      MODE_SCAN   = 2'b01,
      MODE_MASKED = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EMIT = 2'b01,
      FIN  = 2'b10
   } state_t;

endpackage

// File: rtl/mux_tree_n.sv
// Combinational N:1 selector of W-bit words built from 2:1 stages.
// Leaves past N are tied to zero, so an out-of-range select yields 0.
module mux_tree_n #(
   parameter  int W    = 8,
   parameter  int N    = 16,
   localparam int SELW = $clog2(N)
) (
   input  logic [N*W-1:0]  in_data,
   input  logic [SELW-1:0] sel,
   output logic [W-1:0]    out_data
);

   localparam int P = 1 << SELW;

   // Level l holds P>>l nodes; level l picks between pairs using select bit l-1.
   for (genvar l = 0; l <= SELW; l++) begin : g_lvl
      logic [W-1:0] v [P>>l];
      for (genvar i = 0; i < (P >> l); i++) begin : g_node
         if (l == 0) begin : g_leaf
            if (i < N) begin : g_real
               assign v[i] = in_data[i*W +: W];
            end else begin : g_pad
               assign v[i] = '0;
            end
         end else begin : g_mux
            assign v[i] = sel[l-1] ? g_lvl[l-1].v[2*i+1] : g_lvl[l-1].v[2*i];
         end
      end
   end

   assign out_data = g_lvl[SELW].v[0];

endmodule

// File: rtl/mux_scan_n.sv
// Registered N-channel multiplexer with FIXED / SCAN / MASKED channel sequencing
// and a valid/ready output handshake.
//
//  state | meaning
//  IDLE  | waiting for start; busy=0
//  EMIT  | out_valid=1, word held until out_ready
//  FIN   | one-cycle done pulse, then back to IDLE
module mux_scan_n
   import mux_pkg::*;
#(
   parameter  int W    = 8,
   parameter  int N    = 16,
   localparam int SELW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N*W-1:0]  in_data,
   input  logic [1:0]      mode,
   input  logic [SELW-1:0] sel_in,
   input  logic [N-1:0]    en_mask,
   input  logic            start,
   input  logic            out_ready,
   output logic            out_valid,
   output logic [W-1:0]    out_data,
   output logic [SELW-1:0] out_chan,
   output logic            busy,
   output logic            done
);

   state_t          state_q, state_d;
   mode_t           mode_q, mode_d;
   logic [N-1:0]    mask_q, mask_d;
   logic [SELW-1:0] chan_q, chan_d;
   logic [W-1:0]    data_q;
   logic [W-1:0]    tree_out;
   logic            capture;

   logic            first_any;
   logic [SELW-1:0] first_chan;
   logic            next_any;
   logic [SELW-1:0] next_chan;
   logic            scan_last;

   // Lowest enabled channel of the incoming mask, used when a MASKED run starts.
   always_comb begin
      first_any  = 1'b0;
      first_chan = '0;
      for (int c = N - 1; c >= 0; c--) begin
         if (en_mask[c]) begin
            first_any  = 1'b1;
            first_chan = SELW'(c);
         end
      end
   end

   // Lowest enabled channel strictly above the current one.
   always_comb begin
      next_any  = 1'b0;
      next_chan = '0;
      for (int c = N - 1; c >= 0; c--) begin
         if (mask_q[c] && (c > int'(chan_q))) begin
            next_any  = 1'b1;
            next_chan = SELW'(c);
         end
      end
   end

   assign scan_last = (int'(chan_q) == N - 1);

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      mask_d  = mask_q;
      chan_d  = chan_q;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               mode_d = mode_t'(mode);
               mask_d = en_mask;
               case (mode_t'(mode))
                  MODE_SCAN: begin
                     chan_d  = '0;
                     capture = 1'b1;
                     state_d = EMIT;
                  end
                  MODE_MASKED: begin
                     if (first_any) begin
                        chan_d  = first_chan;
                        capture = 1'b1;
                        state_d = EMIT;
                     end else begin
                        state_d = FIN;
                     end
                  end
                  default: begin
                     chan_d  = sel_in;
                     capture = 1'b1;
                     state_d = EMIT;
                  end
               endcase
            end
         end
         EMIT: begin
            if (out_ready) begin
               case (mode_q)
                  MODE_SCAN: begin
                     if (!scan_last) begin
                        chan_d  = chan_q + 1'b1;
                        capture = 1'b1;
                     end else begin
                        state_d = FIN;
                     end
                  end
                  MODE_MASKED: begin
                     if (next_any) begin
                        chan_d  = next_chan;
                        capture = 1'b1;
                     end else begin
                        state_d = FIN;
                     end
                  end
                  default: state_d = FIN;
               endcase
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The tree looks at the channel being loaded so data and tag land on the same edge.
   mux_tree_n #(.W(W), .N(N)) u_tree (
      .in_data  (in_data),
      .sel      (chan_d),
      .out_data (tree_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mode_q  <= MODE_FIXED;
         mask_q  <= '0;
         chan_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         mask_q  <= mask_d;
         chan_q  <= chan_d;
         if (capture) begin
            data_q <= tree_out;
         end
      end
   end

   assign out_valid = (state_q == EMIT);
   assign busy      = (state_q == EMIT);
   assign done      = (state_q == FIN);
   assign out_data  = data_q;
   assign out_chan  = chan_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: table of operations scored against a queue of expected
// words, plus hand sequences for backpressure, ignored starts, reset and N=12.
module tb_mux_scan_n;

   logic         clk;
   logic         rst_n;
   logic [127:0] in_data;
   logic [1:0]   mode;
   logic [3:0]   sel_in;
   logic [15:0]  en_mask;
   logic         start;
   logic         out_ready;
   logic         out_valid;
   logic [7:0]   out_data;
   logic [3:0]   out_chan;
   logic         busy;
   logic         done;

   logic [95:0]  in_data12;
   logic [1:0]   mode12;
   logic [3:0]   sel12;
   logic [11:0]  mask12;
   logic         start12;
   logic         ready12;
   logic         valid12;
   logic [7:0]   data12;
   logic [3:0]   chan12;
   logic         busy12;
   logic         done12;

   mux_scan_n #(.W(8), .N(16)) dut (
      .clk (clk), .rst_n (rst_n), .in_data (in_data), .mode (mode),
      .sel_in (sel_in), .en_mask (en_mask), .start (start), .out_ready (out_ready),
      .out_valid (out_valid), .out_data (out_data), .out_chan (out_chan),
      .busy (busy), .done (done)
   );

   mux_scan_n #(.W(8), .N(12)) dut12 (
      .clk (clk), .rst_n (rst_n), .in_data (in_data12), .mode (mode12),
      .sel_in (sel12), .en_mask (mask12), .start (start12), .out_ready (ready12),
      .out_valid (valid12), .out_data (data12), .out_chan (chan12),
      .busy (busy12), .done (done12)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [7:0] data;
      logic [3:0] chan;
   } exp_t;

   typedef struct {
      logic [1:0]  mode;
      logic [3:0]  sel;
      logic [15:0] mask;
      int          cnt;
   } vec_t;

   exp_t exp_q[$];
   exp_t mon_e;
   vec_t vecs[10];
   int   n_pass  = 0;
   int   n_total = 0;
   int   word_cnt = 0;
   int   cyc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push_expected(input logic [1:0] m, input logic [3:0] s, input logic [15:0] k);
      case (m)
         2'b01: for (int c = 0; c < 16; c++) exp_q.push_back('{8'(16 + c), 4'(c)});
         2'b10: for (int c = 0; c < 16; c++) if (k[c]) exp_q.push_back('{8'(16 + c), 4'(c)});
         default: exp_q.push_back('{8'(16 + int'(s)), s});
      endcase
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      while (!done && cycles < 300) begin
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   task automatic issue_start(input logic [1:0] m, input logic [3:0] s, input logic [15:0] k);
      @(posedge clk); #1;
      mode = m; sel_in = s; en_mask = k; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_vec(input logic [1:0] m, input logic [3:0] s, input logic [15:0] k, input int cnt);
      int c;
      word_cnt = 0;
      push_expected(m, s, k);
      issue_start(m, s, k);
      chk("latency_valid", 32'(out_valid), 32'(cnt != 0));
      wait_done(c);
      chk("done_cycles", c, cnt);
      chk("word_count", word_cnt, cnt);
      chk("queue_empty", exp_q.size(), 0);
      chk("busy_at_done", 32'(busy), 0);
      @(posedge clk); #1;
      chk("done_pulse_width", 32'(done), 0);
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         word_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_word", 32'(out_chan), 32'hFFFF);
         end else begin
            mon_e = exp_q.pop_front();
            chk("word_data", 32'(out_data), 32'(mon_e.data));
            chk("word_chan", 32'(out_chan), 32'(mon_e.chan));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{2'b00, 4'd5,  16'h0000, 1};
      vecs[1] = '{2'b01, 4'd0,  16'h0000, 16};
      vecs[2] = '{2'b10, 4'd0,  16'h8421, 4};
      vecs[3] = '{2'b10, 4'd3,  16'h0000, 0};
      vecs[4] = '{2'b11, 4'd9,  16'h0000, 1};
      vecs[5] = '{2'b10, 4'd0,  16'h8000, 1};
      vecs[6] = '{2'b10, 4'd0,  16'h0001, 1};
      vecs[7] = '{2'b00, 4'd15, 16'hFFFF, 1};
      vecs[8] = '{2'b00, 4'd0,  16'h0000, 1};
      vecs[9] = '{2'b10, 4'd0,  16'hFFFF, 16};

      for (int c = 0; c < 16; c++) in_data[c*8 +: 8] = 8'(16 + c);
      for (int c = 0; c < 12; c++) in_data12[c*8 +: 8] = 8'(16 + c);
      rst_n = 1'b0; mode = 2'b00; sel_in = 4'd0; en_mask = 16'h0; start = 1'b0; out_ready = 1'b1;
      mode12 = 2'b00; sel12 = 4'd0; mask12 = 12'h0; start12 = 1'b0; ready12 = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_chan", 32'(out_chan), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      rst_n = 1'b1;

      for (int v = 0; v < 10; v++) run_vec(vecs[v].mode, vecs[v].sel, vecs[v].mask, vecs[v].cnt);

      // backpressure at ch3 with ch3 input disturbed while stalled
      word_cnt = 0;
      push_expected(2'b01, 4'd0, 16'h0);
      issue_start(2'b01, 4'd0, 16'h0);
      repeat (3) begin @(posedge clk); #1; end
      out_ready = 1'b0;
      in_data[3*8 +: 8] = 8'hAA;
      repeat (3) begin
         @(posedge clk); #1;
         chk("bp_hold_data", 32'(out_data), 32'h13);
         chk("bp_hold_chan", 32'(out_chan), 3);
         chk("bp_hold_valid", 32'(out_valid), 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_data[3*8 +: 8] = 8'h13;
      chk("bp_next_chan", 32'(out_chan), 4);
      chk("bp_next_data", 32'(out_data), 32'h14);
      wait_done(cyc);
      chk("bp_word_count", word_cnt, 16);
      chk("bp_queue_empty", exp_q.size(), 0);

      // start pulsed mid-SCAN must not disturb the running operation
      word_cnt = 0;
      push_expected(2'b01, 4'd0, 16'h0);
      issue_start(2'b01, 4'd0, 16'h0);
      repeat (4) begin @(posedge clk); #1; end
      mode = 2'b00; sel_in = 4'd2; en_mask = 16'h0001; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_start_chan", 32'(out_chan), 5);
      wait_done(cyc);
      chk("busy_start_words", word_cnt, 16);
      chk("busy_start_queue", exp_q.size(), 0);

      // start held into FIN is ignored
      @(posedge clk); #1;
      mode = 2'b10; en_mask = 16'h0; start = 1'b1;
      @(posedge clk); #1;
      chk("fin_done", 32'(done), 1);
      mode = 2'b00; sel_in = 4'd1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("fin_start_valid", 32'(out_valid), 0);
      chk("fin_start_busy", 32'(busy), 0);
      chk("fin_start_done", 32'(done), 0);

      // asynchronous reset at ch7, then a fresh scan
      word_cnt = 0;
      push_expected(2'b01, 4'd0, 16'h0);
      issue_start(2'b01, 4'd0, 16'h0);
      repeat (7) begin @(posedge clk); #1; end
      chk("pre_rst_chan", 32'(out_chan), 7);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_data", 32'(out_data), 0);
      chk("mid_rst_chan", 32'(out_chan), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_vec(2'b01, 4'd0, 16'h0, 16);

      // N=12: out-of-range and in-range FIXED selects
      @(posedge clk); #1;
      mode12 = 2'b00; sel12 = 4'd14; start12 = 1'b1;
      @(posedge clk); #1;
      start12 = 1'b0;
      chk("n12_oor_valid", 32'(valid12), 1);
      chk("n12_oor_data", 32'(data12), 0);
      chk("n12_oor_chan", 32'(chan12), 14);
      @(posedge clk); #1;
      chk("n12_oor_done", 32'(done12), 1);
      chk("n12_oor_valid_off", 32'(valid12), 0);
      @(posedge clk); #1;
      chk("n12_oor_done_off", 32'(done12), 0);
      sel12 = 4'd11; start12 = 1'b1;
      @(posedge clk); #1;
      start12 = 1'b0;
      chk("n12_top_data", 32'(data12), 32'h1B);
      chk("n12_top_chan", 32'(chan12), 11);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
